usb_uart_tx_fifo: RTL and testbench

byte FIFO directly upstream of the USB-UART bridge IN path. It absorbs CPU writes and feeds the bridge's uart_wr/uart_busy/uart_tx_data port one byte at a time.

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameter DEPTH_LOG2 SHALL default to 4 and set FIFO depth to 2^DEPTH_LOG2 bytes; legal values are 2..8.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cpu_wr  in  1  one-cycle write strobe from the CPU side.
REQ-006 cpu_data  in  8  byte written when cpu_wr=1.
REQ-007 cpu_busy  out  1  FIFO full; the CPU must not write while it is high.
REQ-008 bridge_wr  out  1  registered one-cycle pulse, connected to the bridge's uart_wr.
REQ-009 bridge_data  out  8  registered byte, valid in the bridge_wr cycle, connected to the bridge's uart_tx_data.
REQ-010 bridge_busy  in  1  connected to the bridge's uart_busy.
REQ-011 level  out  DEPTH_LOG2+1  current occupancy; present only under USB_TX_LEVEL_EN.

Function
REQ-012 Storage SHALL be 2^DEPTH_LOG2 x 8 with DEPTH_LOG2-bit read/write pointers that wrap modulo depth, plus a DEPTH_LOG2+1-bit count.
REQ-013 cpu_busy SHALL be combinational (count == 2^DEPTH_LOG2).
REQ-014 A push SHALL occur on an edge where cpu_wr=1 and the FIFO is not full: store cpu_data at wr_ptr, then increment wr_ptr.
REQ-015 A cpu_wr while full SHALL be dropped, with no change to storage, pointers or count.
REQ-016 Drain FSM states SHALL be IDLE, SENT, HOLD; IDLE is the reset state.
REQ-017 IDLE: if count != 0 and bridge_busy = 0, the FSM SHALL pop: bridge_data <= mem[rd_ptr], bridge_wr <= 1, rd_ptr++, then go to SENT. Otherwise it stays in IDLE.
REQ-018 SENT: bridge_wr <= 0, and the FSM SHALL go to HOLD unconditionally. This state covers the one-cycle delay before the bridge's uart_busy rises.
REQ-019 HOLD: the FSM SHALL go to IDLE when bridge_busy = 0, and stay in HOLD otherwise.
REQ-020 A push and a pop on the same edge SHALL leave count unchanged; each alone SHALL change count by +1 or -1.
REQ-021 A push and a pop on the same edge with the FIFO full SHALL be impossible, because the push is rejected by REQ-015 and count then decrements.
REQ-022 There SHALL be no bypass: a byte written into an empty FIFO on edge N SHALL produce bridge_wr high after edge N+1, i.e. 2-cycle latency.
REQ-023 bridge_wr SHALL never be high in two consecutive cycles, and SHALL not be asserted again until HOLD has seen bridge_busy = 0.
REQ-024 Bytes SHALL reach bridge_data in exact write order, including across pointer wrap.
REQ-025 bridge_data SHALL hold its last value when bridge_wr = 0.

Reset
REQ-026 On reset_n = 0 the block SHALL immediately reset: pointers = 0, count = 0, state = IDLE, bridge_wr = 0, bridge_data = 0, and, when compiled in, level = 0.
REQ-027 Reset mid-operation SHALL discard all stored bytes. cpu_busy SHALL be 0 while reset is asserted.
REQ-028 Storage contents SHALL not need reset.
REQ-029 The first pop after reset release SHALL occur no earlier than the second edge after the first accepted write.

Configuration
REQ-030 With macro USB_TX_LEVEL_EN defined, port level SHALL exist and equal count, registered and updated on the same edge as count.
REQ-031 Without USB_TX_LEVEL_EN, port level SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Single byte: write 0x41 into an empty FIFO with bridge_busy = 0 -> bridge_wr high exactly 2 cycles later with bridge_data = 0x41, high for one cycle only.
REQ-033 Burst with bridge model (busy rises 1 cycle after bridge_wr, holds 4 cycles): write 0x00..0x0F back-to-back -> 16 bridge_wr pulses carrying 0x00..0x0F in order, no two pulses closer than 6 cycles.
REQ-034 Full/overflow, DEPTH_LOG2 = 4, bridge_busy held 1: write 17 bytes 0x10..0x20 -> cpu_busy = 1 after 16 writes, 0x20 dropped. After releasing busy, exactly 0x10..0x1F emerge.
REQ-035 Simultaneous p

---
 rtl/usb_uart_tx_fifo.sv | 131 +++++++++++++
 tb/tb_usb_uart_tx_fifo.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_uart_tx_fifo.sv
// usb_uart_tx_fifo: byte FIFO that buffers CPU writes for the USB-UART
// bridge IN path. The bridge is fed one byte per uart_wr pulse, and the
// next pulse waits until the bridge's uart_busy has risen and fallen again.
//
// Ports:
//   clk          rising-edge clock for all state
//   reset_n      asynchronous active-low reset
//   cpu_wr       one-cycle write strobe from the CPU
//   cpu_data     byte written when cpu_wr is high
//   cpu_busy     FIFO full; the CPU must not write while it is high
//   bridge_wr    registered one-cycle pulse to the bridge's uart_wr
//   bridge_data  registered byte, valid while bridge_wr is high
//   bridge_busy  the bridge's uart_busy
//   level        occupancy, present only with USB_TX_LEVEL_EN defined
//
// Optional feature macro: USB_TX_LEVEL_EN adds the level output.

module usb_uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cpu_wr,
    input  logic [7:0]          cpu_data,
    output logic                cpu_busy,
    output logic                bridge_wr,
    output logic [7:0]          bridge_data,
    input  logic                bridge_busy
`ifdef USB_TX_LEVEL_EN
    ,
    output logic [DEPTH_LOG2:0] level
`else
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SENT,
        HOLD
    } state_e;

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  bridge_wr_q, bridge_wr_d;
    logic [7:0]            bridge_data_q, bridge_data_d;
    logic [7:0]            mem_q [DEPTH];
    logic                  push;
    logic                  pop;

    // A write while full is simply dropped.
    assign cpu_busy = (count_q == FULL);
    assign push     = cpu_wr && !cpu_busy;

    // Drain FSM: SENT covers the cycle before the bridge raises busy,
    // HOLD waits for it to fall before the next pop is allowed.
    always_comb begin
        state_d       = state_q;
        rd_ptr_d      = rd_ptr_q;
        bridge_wr_d   = 1'b0;
        bridge_data_d = bridge_data_q;
        pop           = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0 && !bridge_busy) begin
                    pop           = 1'b1;
                    bridge_data_d = mem_q[rd_ptr_q];
                    bridge_wr_d   = 1'b1;
                    rd_ptr_d      = rd_ptr_q + 1'b1;
                    state_d       = SENT;
                end
            end
            SENT: state_d = HOLD;
            HOLD: begin
                if (!bridge_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            bridge_wr_q   <= 1'b0;
            bridge_data_q <= 8'h00;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            bridge_wr_q   <= bridge_wr_d;
            bridge_data_q <= bridge_data_d;
        end
    end

    // Storage carries no reset; stale bytes are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cpu_data;
        end
    end

    assign bridge_wr   = bridge_wr_q;
    assign bridge_data = bridge_data_q;

`ifdef USB_TX_LEVEL_EN
    assign level = count_q;
`else
`endif

endmodule

// File: tb/tb_usb_uart_tx_fifo.sv
// tb_usb_uart_tx_fifo: randomized bench for usb_uart_tx_fifo with a
// queue-based reference model and a behavioural bridge busy generator.

module tb_usb_uart_tx_fifo;

    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       cpu_wr = 1'b0;
    logic [7:0] cpu_data = 8'h00;
    logic       cpu_busy;
    logic       bridge_wr;
    logic [7:0] bridge_data;
    logic       bridge_busy = 1'b0;
`ifdef USB_TX_LEVEL_EN
    logic [DL:0] level;
`else
`endif

    usb_uart_tx_fifo #(.DEPTH_LOG2(DL)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_wr      (cpu_wr),
        .cpu_data    (cpu_data),
        .cpu_busy    (cpu_busy),
        .bridge_wr   (bridge_wr),
        .bridge_data (bridge_data),
        .bridge_busy (bridge_busy)
`ifdef USB_TX_LEVEL_EN
        ,
        .level       (level)
`else
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: FIFO contents, last delivered byte, and the pacing
    // rule "after a pulse, skip one edge, then an edge with busy low must
    // pass before another pulse may be issued".
    byte unsigned q[$];
    logic [7:0]   m_last;
    bit           m_rel;
    bit           m_wr;
    int           t;
    int           last_pop;

    int mode;        // 0 busy low, 1 bridge model, 2 busy high, 3 bridge+random
    int brg_cnt;
    int cyc;
    int last_wr_cyc;
    int n_pulse;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last   = 8'h00;
        m_rel    = 1'b1;
        m_wr     = 1'b0;
        t        = 0;
        last_pop = 0;
    endtask

    task automatic model_edge(input bit wr, input logic [7:0] d,
                              input bit busy);
        bit can_pop;
        bit can_push;
        can_pop  = m_rel && q.size() > 0 && !busy;
        can_push = wr && q.size() < DEPTH;
        m_wr = 1'b0;
        if (can_pop) begin
            m_last   = q.pop_front();
            m_wr     = 1'b1;
            m_rel    = 1'b0;
            last_pop = t;
        end else if (!m_rel && t >= last_pop + 2 && !busy) begin
            m_rel = 1'b1;
        end
        if (can_push) q.push_back(d);
        t++;
    endtask

    task automatic step(input bit wr, input logic [7:0] d);
        bit b;
        cpu_wr   = wr;
        cpu_data = d;
        case (mode)
            0:       b = 1'b0;
            1:       b = (brg_cnt != 0);
            2:       b = 1'b1;
            default: b = (brg_cnt != 0) || ($urandom_range(2) == 0);
        endcase
        if (brg_cnt > 0) brg_cnt--;
        bridge_busy = b;
        @(posedge clk);
        model_edge(wr, d, b);
        #1;
        cyc++;
        chk("bridge_wr", bridge_wr, m_wr);
        chk("bridge_data", bridge_data, m_last);
        chk("cpu_busy", cpu_busy, q.size() == DEPTH);
`ifdef USB_TX_LEVEL_EN
        chk("level", level, q.size());
`else
`endif
        if (bridge_wr) begin
            brg_cnt = 4;
            n_pulse++;
            if (mode == 1 && last_wr_cyc >= 0)
                chk("pulse_gap_ge6", (cyc - last_wr_cyc) >= 6, 1);
            last_wr_cyc = cyc;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && (q.size() > 0 || !m_rel); i++)
            step(1'b0, 8'h00);
        repeat (8) step(1'b0, 8'h00);
    endtask

    initial begin
        cyc = 0;
        brg_cnt = 0;
        last_wr_cyc = -1;
        n_pulse = 0;
        mode = 0;
        model_reset();

        #1 reset_n = 1'b0;
        #1;
        chk("rst_wr", bridge_wr, 0);
        chk("rst_data", bridge_data, 0);
        chk("rst_busy", cpu_busy, 0);
`ifdef USB_TX_LEVEL_EN
        chk("rst_level", level, 0);
`else
`endif
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (3) step(1'b0, 8'h00);

        // Single byte, two-cycle latency, one-cycle pulse.
        step(1'b1, 8'h41);
        chk("single_early", bridge_wr, 0);
        step(1'b0, 8'h00);
        chk("single_wr", bridge_wr, 1);
        chk("single_data", bridge_data, 8'h41);
        step(1'b0, 8'h00);
        chk("single_once", bridge_wr, 0);
        drain();

        // Burst against the bridge model.
        mode = 1;
        last_wr_cyc = -1;
        n_pulse = 0;
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i));
        drain();
        chk("burst_pulses", n_pulse, 16);

        // Overflow with the bridge stalled.
        mode = 2;
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 8'(8'h10 + i));
            if (i == 15) chk("full_after16", cpu_busy, 1);
        end
        chk("full_hold", cpu_busy, 1);
        mode = 1;
        last_wr_cyc = -1;
        n_pulse = 0;
        drain();
        chk("overflow_pulses", n_pulse, 16);
        chk("overflow_last", bridge_data, 8'h1F);

        // Simultaneous push and pop with three bytes held.
        mode = 2;
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i));
        mode = 0;
        step(1'b1, 8'h33);
        chk("pp_pop", bridge_wr, 1);
        chk("pp_data", bridge_data, 8'h30);
`ifdef USB_TX_LEVEL_EN
        chk("pp_level", level, 3);
`else
`endif
        drain();

        // Pointer wrap with random stalls.
        mode = 3;
        for (int i = 0; i < 40; i++) begin
            while (cpu_busy) step(1'b0, 8'h00);
            step(1'b1, 8'(8'h80 + i));
            repeat ($urandom_range(2)) step(1'b0, 8'h00);
        end
        drain();
        chk("wrap_last", bridge_data, 8'hA7);

        // Fully random traffic, including writes while full.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(1)), 8'($urandom));
        drain();

        // Reset mid-burst, in the cycle of a pulse with five bytes left.
        mode = 2;
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hC0 + i));
        mode = 1;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                step(1'b0, 8'h00);
                seen = bridge_wr;
            end
            chk("rst_pulse_seen", seen, 1);
        end
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_wr", bridge_wr, 0);
        chk("midrst_busy", cpu_busy, 0);
        chk("midrst_data", bridge_data, 0);
        model_reset();
        brg_cnt = 0;
        cpu_wr = 1'b0;
        bridge_busy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        mode = 0;
        n_pulse = 0;
        repeat (12) step(1'b0, 8'h00);
        chk("post_rst_quiet", n_pulse, 0);
        step(1'b1, 8'h55);
        drain();
        chk("post_rst_byte", bridge_data, 8'h55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
